// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signal bundle for load_store_unit
interface load_store_unit_if;
  // requester side
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  // data memory side
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_readdata;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_readdata,
    output busy, done, err, rdata, mem_address, mem_writeData, mem_read, mem_write
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_readdata,
    input  busy, done, err, rdata, mem_address, mem_writeData, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store unit with read-modify-write stores; optional LSU_ALIGN_CHECK_EN
module load_store_unit (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rword;
  logic [31:0] r_rdata;
  logic        r_rej;

  logic        w_misalign;
  logic        w_reject;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ((bus.size == 2'b01) && bus.addr[0]) ||
                      ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // size 11 is never a legal access, regardless of alignment checking
  assign w_reject = (bus.size == 2'b11) | w_misalign;

  // next-state selection; word stores skip the read, sub-word stores read first
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_reject)                          w_next = S_RESP;
          else if (bus.we && bus.size == 2'b10)  w_next = S_WRITE;
          else                                   w_next = S_READ;
        end
      end
      S_READ:  w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // lane extraction and extension of the word returned by memory
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus.mem_readdata[7:0];
      2'd1:    w_byte = bus.mem_readdata[15:8];
      2'd2:    w_byte = bus.mem_readdata[23:16];
      default: w_byte = bus.mem_readdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = bus.mem_readdata;
    endcase
  end

  // merge store data into the previously read word; a word store replaces it whole
  always_comb begin
    w_merge = r_rword;
    case (r_size)
      2'b00: begin
        case (r_addr[1:0])
          2'd0:    w_merge[7:0]   = r_wdata[7:0];
          2'd1:    w_merge[15:8]  = r_wdata[7:0];
          2'd2:    w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  // state, request latching and read capture; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rword <= 32'd0;
      r_rdata <= 32'd0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sext  <= bus.sign_ext;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_rej   <= w_reject;
          end
        end
        S_READ: begin
          r_rword <= bus.mem_readdata;
          if (!r_we) r_rdata <= w_load;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_RESP);
  assign bus.err           = (r_state == S_RESP) & r_rej;
  assign bus.rdata         = r_rdata;
  assign bus.mem_address   = {r_addr[31:2], 2'b00};
  assign bus.mem_writeData = w_merge;
  // gated by rst so nothing reaches memory during a reset cycle
  assign bus.mem_read      = (r_state == S_READ)  & ~rst;
  assign bus.mem_write     = (r_state == S_WRITE) & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data memory: acts on negedge, 16 words
  logic [31:0] mem [0:15];
  always @(negedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[5:2]] = bus.mem_writeData;
    if (bus.mem_read)  bus.mem_readdata = mem[bus.mem_address[5:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int          lat, nrd, nwr, ndone;
  logic        seen_err;
  logic [31:0] exp_rdata;

  // issue one access from IDLE and observe it for a bounded number of cycles
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = d;
    lat = 0; nrd = 0; nwr = 0; ndone = 0; seen_err = 1'b0;
    tick;
    bus.req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      nrd += int'(bus.mem_read);
      nwr += int'(bus.mem_write);
      if (bus.done) begin
        if (ndone == 0) lat = c;
        ndone++;
        seen_err = bus.err;
      end
      tick;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = i * 32'h01010101;
    mem[4] = 32'h8899AABB;
    mem[8] = 32'hCAFEF00D;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'd0; bus.wdata = 32'd0; bus.mem_readdata = 32'd0;
    rst = 1'b1;
    tick;
    tick;
    check_eq("rst_mem_read",  {31'd0, bus.mem_read},  32'd0);
    check_eq("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    rst = 1'b0;
    tick;
    check_eq("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done",  {31'd0, bus.done}, 32'd0);
    check_eq("rst_err",   {31'd0, bus.err},  32'd0);
    check_eq("rst_rdata", bus.rdata,         32'd0);

    // load word
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check_eq("lw_lat",   lat, 2);
    check_eq("lw_rdata", bus.rdata, 32'h8899AABB);
    check_eq("lw_err",   {31'd0, seen_err}, 32'd0);
    check_eq("lw_reads", nrd, 1);
    check_eq("lw_writes", nwr, 0);
    check_eq("lw_dones", ndone, 1);

    // byte loads
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    check_eq("lb_13_sx", bus.rdata, 32'hFFFFFF88);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    check_eq("lb_13_zx", bus.rdata, 32'h00000088);
    access(1'b0, 2'b00, 1'b1, 32'h10, 32'd0);
    check_eq("lb_10_sx", bus.rdata, 32'hFFFFFFBB);
    check_eq("lb_lat", lat, 2);

    // halfword loads
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    check_eq("lh_12_zx", bus.rdata, 32'h00008899);
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'd0);
    check_eq("lh_10_sx", bus.rdata, 32'hFFFFAABB);
    exp_rdata = 32'hFFFFAABB;

    // misaligned halfword load
    access(1'b0, 2'b01, 1'b1, 32'h13, 32'd0);
`ifdef LSU_ALIGN_CHECK_EN
    check_eq("lh_mis_err",   {31'd0, seen_err}, 32'd1);
    check_eq("lh_mis_lat",   lat, 1);
    check_eq("lh_mis_reads", nrd, 0);
    check_eq("lh_mis_rdata", bus.rdata, exp_rdata);
`else
    check_eq("lh_mis_err",   {31'd0, seen_err}, 32'd0);
    check_eq("lh_mis_lat",   lat, 2);
    check_eq("lh_mis_rdata", bus.rdata, 32'hFFFF8899);
    exp_rdata = 32'hFFFF8899;
`endif

    // byte store: read-modify-write, only low byte of wdata used
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55);
    check_eq("sb_lat",    lat, 3);
    check_eq("sb_reads",  nrd, 1);
    check_eq("sb_writes", nwr, 1);
    check_eq("sb_mem",    mem[4], 32'h889955BB);
    check_eq("sb_rdata",  bus.rdata, exp_rdata);

    // word store: no read
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF);
    check_eq("sw_lat",    lat, 2);
    check_eq("sw_reads",  nrd, 0);
    check_eq("sw_writes", nwr, 1);
    check_eq("sw_mem",    mem[12], 32'hDEADBEEF);

    // upper halfword store
    access(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234ABCD);
    check_eq("sh_lat", lat, 3);
    check_eq("sh_mem", mem[12], 32'hABCDBEEF);

    // reserved size
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    check_eq("rsv_err",   {31'd0, seen_err}, 32'd1);
    check_eq("rsv_lat",   lat, 1);
    check_eq("rsv_reads", nrd, 0);
    check_eq("rsv_rdata", bus.rdata, exp_rdata);

    // misaligned word load
    access(1'b0, 2'b10, 1'b0, 32'h31, 32'd0);
`ifdef LSU_ALIGN_CHECK_EN
    check_eq("lw_mis_err",   {31'd0, seen_err}, 32'd1);
    check_eq("lw_mis_reads", nrd, 0);
`else
    check_eq("lw_mis_err",   {31'd0, seen_err}, 32'd0);
    check_eq("lw_mis_rdata", bus.rdata, 32'hABCDBEEF);
`endif

    // reset during the WRITE cycle of a word store
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = 32'h20; bus.wdata = 32'h12345678;
    tick;
    bus.req = 1'b0;
    check_eq("abort_pre_wr", {31'd0, bus.mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_wr", {31'd0, bus.mem_write}, 32'd0);
    tick;
    check_eq("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check_eq("abort_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    tick;
    check_eq("abort_mem", mem[8], 32'hCAFEF00D);

    // req held through READ and RESP must not start a second access
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'd0;
    tick;
    bus.addr = 32'h30; bus.size = 2'b00;
    nrd = 0; ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      nrd   += int'(bus.mem_read);
      ndone += int'(bus.done);
      if (c == 3) bus.req = 1'b0;
      tick;
    end
    check_eq("busy_reads", nrd, 1);
    check_eq("busy_dones", ndone, 1);
    check_eq("busy_rdata", bus.rdata, 32'h889955BB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
